// File: rtl/tile_fp_pkg.sv
// Shared types for the FP adder tile ingress: operand beat layout and default widths.
package tile_fp_pkg;

  localparam int unsigned FP_BW  = 32;
  localparam int unsigned FP_BWB = 4;

  typedef struct packed {
    logic [FP_BW-1:0]  data;
    logic [FP_BWB-1:0] keep;
    logic              last;
  } fp_beat_t;

endpackage

// File: rtl/fp_pair_fifo.sv
// Circular-buffer FIFO of operand beats with a registered full flag that drives upstream TREADY.
module fp_pair_fifo
  import tile_fp_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic     clk_line,
  input  logic     rst_i,
  input  logic     push_i,
  input  fp_beat_t wdata_i,
  input  logic     pop_i,
  output fp_beat_t rdata_o,
  output logic     full_o,
  output logic     empty_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  fp_beat_t        mem_q [DEPTH];
  logic [PW-1:0]   wptr_q, wptr_d;
  logic [PW-1:0]   rptr_q, rptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            full_q, full_d;
  logic            push_ok, pop_ok;

  assign push_ok = push_i && !full_q;
  assign pop_ok  = pop_i && (count_q != '0);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_ok) wptr_d = wptr_q + PW'(1);
    if (pop_ok)  rptr_d = rptr_q + PW'(1);
    if (push_ok && !pop_ok)      count_d = count_q + CW'(1);
    else if (!push_ok && pop_ok) count_d = count_q - CW'(1);
    full_d = (count_d == CW'(DEPTH));
  end

  // full_q is forced high in reset so upstream sees TREADY low until the flush completes.
  always_ff @(posedge clk_line) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b1;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      full_q  <= full_d;
    end
  end

  always_ff @(posedge clk_line) begin
    if (push_ok) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q];
  assign full_o  = full_q;
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/fp_operand_pairer.sv
// Pairs independent A/B operand streams into one {B,A} beat per cycle for the FP adder,
// flagging TLAST disagreement and counting accepted pairs.
module fp_operand_pairer
  import tile_fp_pkg::*;
#(
  parameter int unsigned BW    = FP_BW,
  parameter int unsigned BWB   = BW / 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic               clk_line,
  input  logic               clk_line_rst_high,
  input  logic               a_TVALID,
  input  logic [BW-1:0]      a_TDATA,
  input  logic [BWB-1:0]     a_TKEEP,
  input  logic               a_TLAST,
  output logic               a_TREADY,
  input  logic               b_TVALID,
  input  logic [BW-1:0]      b_TDATA,
  input  logic [BWB-1:0]     b_TKEEP,
  input  logic               b_TLAST,
  output logic               b_TREADY,
  output logic               out_TVALID,
  output logic [2*BW-1:0]    out_TDATA,
  output logic [2*BWB-1:0]   out_TKEEP,
  output logic               out_TLAST,
  input  logic               out_TREADY,
  input  logic               clear_err,
  output logic               err_last_mismatch,
  output logic [CNT_W-1:0]   pair_count
);

  fp_beat_t a_wr, b_wr, a_rd, b_rd;
  logic     a_full, b_full, a_empty, b_empty;
  logic     pair_pop;

  logic               out_valid_q, out_valid_d;
  logic [2*BW-1:0]    out_data_q, out_data_d;
  logic [2*BWB-1:0]   out_keep_q, out_keep_d;
  logic               out_last_q, out_last_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  assign a_wr = '{data: a_TDATA, keep: a_TKEEP, last: a_TLAST};
  assign b_wr = '{data: b_TDATA, keep: b_TKEEP, last: b_TLAST};

  fp_pair_fifo #(.DEPTH(DEPTH)) u_fifo_a (
    .clk_line (clk_line),
    .rst_i    (clk_line_rst_high),
    .push_i   (a_TVALID && !a_full),
    .wdata_i  (a_wr),
    .pop_i    (pair_pop),
    .rdata_o  (a_rd),
    .full_o   (a_full),
    .empty_o  (a_empty)
  );

  fp_pair_fifo #(.DEPTH(DEPTH)) u_fifo_b (
    .clk_line (clk_line),
    .rst_i    (clk_line_rst_high),
    .push_i   (b_TVALID && !b_full),
    .wdata_i  (b_wr),
    .pop_i    (pair_pop),
    .rdata_o  (b_rd),
    .full_o   (b_full),
    .empty_o  (b_empty)
  );

  assign pair_pop = !a_empty && !b_empty && (!out_valid_q || out_TREADY);

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_keep_d  = out_keep_q;
    out_last_d  = out_last_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    if (pair_pop) begin
      out_valid_d = 1'b1;
      out_data_d  = {b_rd.data, a_rd.data};
      out_keep_d  = {b_rd.keep, a_rd.keep};
      out_last_d  = a_rd.last | b_rd.last;
    end else if (out_TREADY) begin
      out_valid_d = 1'b0;
    end
    // A new mismatch takes priority over a coincident clear.
    if (pair_pop && (a_rd.last != b_rd.last)) err_d = 1'b1;
    else if (clear_err)                       err_d = 1'b0;
    if (out_valid_q && out_TREADY) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_line) begin
    if (clk_line_rst_high) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
      out_last_q  <= out_last_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign a_TREADY          = !a_full;
  assign b_TREADY          = !b_full;
  assign out_TVALID        = out_valid_q;
  assign out_TDATA         = out_data_q;
  assign out_TKEEP         = out_keep_q;
  assign out_TLAST         = out_last_q;
  assign err_last_mismatch = err_q;
  assign pair_count        = cnt_q;

endmodule
